// File: rtl/canvas_mem_ctrl.sv
// Single-port canvas RAM controller: arbitrates VGA reads, brush writes and
// the clear/scan sequencer, and routes registered read data back to its owner.
module canvas_mem_ctrl #(
    parameter int W      = 28,
    parameter int DEPTH  = W * W,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [9:0]        vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              draw_req,
    input  logic [9:0]        draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ack,
    input  logic              clear_start,
    input  logic              scan_start,
    output logic              busy,
    output logic              clear_done,
    output logic              scan_valid,
    output logic [9:0]        scan_index,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_done,
    output logic [9:0]        mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_e;

    localparam logic [9:0] LAST = 10'(DEPTH - 1);

    state_e      state_q;
    logic [9:0]  cnt_q;
    logic        vga_tag_q;
    logic        scan_tag_q;
    logic [9:0]  scan_idx_q;
    logic        clear_done_q;

    logic vga_gnt, clear_gnt, draw_gnt, scan_gnt, seq_last;

    // Grants are suppressed while reset is held so every output reads 0.
    assign vga_gnt   = !rst && vga_req;
    assign clear_gnt = !rst && !vga_req && (state_q == CLEAR);
    assign draw_gnt  = !rst && !vga_req && (state_q == IDLE) && draw_req;
    assign scan_gnt  = !rst && !vga_req && (state_q == SCAN);
    assign seq_last  = (cnt_q == LAST);

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vga_gnt) begin
            mem_addr = vga_addr;
        end else if (clear_gnt) begin
            mem_addr = cnt_q;
            mem_we   = 1'b1;
        end else if (draw_gnt) begin
            mem_addr  = draw_addr;
            mem_we    = (draw_addr <= LAST);
            mem_wdata = draw_data;
        end else if (scan_gnt) begin
            mem_addr = cnt_q;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vga_tag_q    <= 1'b0;
            scan_tag_q   <= 1'b0;
            scan_idx_q   <= '0;
            clear_done_q <= 1'b0;
        end else begin
            vga_tag_q    <= vga_gnt;
            scan_tag_q   <= scan_gnt;
            clear_done_q <= clear_gnt && seq_last;
            if (scan_gnt) begin
                scan_idx_q <= cnt_q;
            end
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end else if (scan_start) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_gnt) begin
                        if (seq_last) state_q <= IDLE;
                        else          cnt_q   <= cnt_q + 10'd1;
                    end
                end
                SCAN: begin
                    if (scan_gnt) begin
                        if (seq_last) state_q <= IDLE;
                        else          cnt_q   <= cnt_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign draw_ack   = draw_gnt;
    assign clear_done = clear_done_q;
    assign vga_valid  = vga_tag_q;
    assign vga_data   = vga_tag_q ? mem_rdata : '0;
    assign scan_valid = scan_tag_q;
    assign scan_index = scan_tag_q ? scan_idx_q : '0;
    assign scan_data  = scan_tag_q ? mem_rdata : '0;
    assign scan_done  = scan_tag_q && (scan_idx_q == LAST);

endmodule
